// File: rtl/quake_detector.sv
// Seismic event detector: reduces three scaled axes to one magnitude, then runs a
// persistence/hysteresis FSM. Define QUAKE_VECTOR_SUM_EN to use the saturated axis sum.
module quake_detector #(
  parameter logic [23:0] TRIG_THRESH    = 24'h040000,
  parameter logic [23:0] RELEASE_THRESH = 24'h020000,
  parameter int unsigned TRIG_COUNT     = 4,
  parameter int unsigned QUIET_COUNT    = 8,
  parameter int unsigned HOLDOFF_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sample_valid,
  input  logic [23:0] i_xdata_scaled,
  input  logic [23:0] i_ydata_scaled,
  input  logic [23:0] i_zdata_scaled,
  input  logic        i_clear_count,
  output logic        o_alarm,
  output logic        o_event_pulse,
  output logic [23:0] o_peak,
  output logic [1:0]  o_peak_axis,
  output logic [7:0]  o_event_count,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPending = 2'd1,
    StAlarm   = 2'd2,
    StHoldoff = 2'd3
  } state_e;

  localparam logic [7:0]  TrigCountL = 8'(TRIG_COUNT);
  localparam logic [7:0]  QuietCountL = 8'(QUIET_COUNT);
  localparam logic [16:0] HoldoffL = 17'(HOLDOFF_CYCLES);

  // Stage 1: axis reduction
  logic [23:0] mag_d, mag_q;
  logic [1:0]  axis_d, axis_q;
  logic        mag_valid_q;

`ifdef QUAKE_VECTOR_SUM_EN
  logic [25:0] sum;
  always_comb begin
    sum    = {2'b00, i_xdata_scaled} + {2'b00, i_ydata_scaled} + {2'b00, i_zdata_scaled};
    mag_d  = (sum > 26'h0FFFFFF) ? 24'hFFFFFF : sum[23:0];
    axis_d = 2'd3;
  end
`else
  always_comb begin
    if (i_xdata_scaled >= i_ydata_scaled && i_xdata_scaled >= i_zdata_scaled) begin
      mag_d  = i_xdata_scaled;
      axis_d = 2'd0;
    end else if (i_ydata_scaled >= i_zdata_scaled) begin
      mag_d  = i_ydata_scaled;
      axis_d = 2'd1;
    end else begin
      mag_d  = i_zdata_scaled;
      axis_d = 2'd2;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mag_valid_q <= 1'b0;
      mag_q       <= '0;
      axis_q      <= '0;
    end else begin
      mag_valid_q <= i_sample_valid;
      if (i_sample_valid) begin
        mag_q  <= mag_d;
        axis_q <= axis_d;
      end
    end
  end

  // Stage 2: persistence / hysteresis FSM
  state_e      state_q;
  logic [7:0]  trig_cnt_q, quiet_cnt_q, event_count_q;
  logic [15:0] hold_cnt_q;
  logic [23:0] peak_q;
  logic [1:0]  peak_axis_q;
  logic        alarm_q, pulse_q;

  logic exceed, quiet, event_start, quiet_done, hold_done;

  always_comb begin
    exceed      = mag_q >= TRIG_THRESH;
    quiet       = mag_q < RELEASE_THRESH;
    event_start = mag_valid_q && exceed &&
                  ((state_q == StIdle && TrigCountL == 8'd1) ||
                   (state_q == StPending && (trig_cnt_q + 8'd1) == TrigCountL));
    quiet_done  = (quiet_cnt_q + 8'd1) == QuietCountL;
    // HOLDOFF_CYCLES of zero still spends exactly one clock in HOLDOFF
    hold_done   = ({1'b0, hold_cnt_q} + 17'd1) >= HoldoffL;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= StIdle;
      trig_cnt_q    <= '0;
      quiet_cnt_q   <= '0;
      hold_cnt_q    <= '0;
      peak_q        <= '0;
      peak_axis_q   <= '0;
      event_count_q <= '0;
      alarm_q       <= 1'b0;
      pulse_q       <= 1'b0;
    end else begin
      pulse_q <= event_start;

      // Clear wins first, then a coincident event counts as one
      if (i_clear_count) begin
        event_count_q <= event_start ? 8'd1 : 8'd0;
      end else if (event_start && event_count_q != 8'hFF) begin
        event_count_q <= event_count_q + 8'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (mag_valid_q && exceed) begin
            peak_q      <= mag_q;
            peak_axis_q <= axis_q;
            trig_cnt_q  <= 8'd1;
            if (event_start) begin
              state_q     <= StAlarm;
              alarm_q     <= 1'b1;
              quiet_cnt_q <= '0;
            end else begin
              state_q <= StPending;
            end
          end
        end
        StPending: begin
          if (mag_valid_q) begin
            if (exceed) begin
              trig_cnt_q <= trig_cnt_q + 8'd1;
              if (mag_q > peak_q) begin
                peak_q      <= mag_q;
                peak_axis_q <= axis_q;
              end
              if (event_start) begin
                state_q     <= StAlarm;
                alarm_q     <= 1'b1;
                quiet_cnt_q <= '0;
              end
            end else begin
              state_q    <= StIdle;
              trig_cnt_q <= '0;
            end
          end
        end
        StAlarm: begin
          if (mag_valid_q) begin
            if (mag_q > peak_q) begin
              peak_q      <= mag_q;
              peak_axis_q <= axis_q;
            end
            if (quiet) begin
              if (quiet_done) begin
                state_q     <= StHoldoff;
                alarm_q     <= 1'b0;
                hold_cnt_q  <= '0;
                quiet_cnt_q <= '0;
                trig_cnt_q  <= '0;
              end else begin
                quiet_cnt_q <= quiet_cnt_q + 8'd1;
              end
            end else begin
              quiet_cnt_q <= '0;
            end
          end
        end
        StHoldoff: begin
          if (hold_done) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_alarm       = alarm_q;
  assign o_event_pulse = pulse_q;
  assign o_peak        = peak_q;
  assign o_peak_axis   = peak_axis_q;
  assign o_event_count = event_count_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_quake_detector.sv
// Self-checking bench for quake_detector: directed scenarios plus randomized traffic
// against an event-level reference model.
module tb_quake_detector;

  localparam logic [23:0] TRIG = 24'h040000;
  localparam logic [23:0] REL  = 24'h020000;
  localparam int TCNT = 4;
  localparam int QCNT = 8;
  localparam int HOLD = 16;
`ifdef QUAKE_VECTOR_SUM_EN
  localparam logic [1:0] XAXIS = 2'd3;
`else
  localparam logic [1:0] XAXIS = 2'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sv = 1'b0;
  logic        clr = 1'b0;
  logic [23:0] x = '0, y = '0, z = '0;
  logic        o_alarm, o_event_pulse;
  logic [23:0] o_peak;
  logic [1:0]  o_peak_axis, o_state;
  logic [7:0]  o_event_count;

  int checks = 0;
  int passed = 0;

  // Reference model state
  int          m_state, m_exc, m_quiet, m_hold, m_count;
  logic [23:0] m_peak;
  logic [1:0]  m_axis;
  bit          m_pulse, m_alarm;
  bit          s1_v;
  logic [23:0] s1_mag;
  logic [1:0]  s1_axis;

  quake_detector #(
    .TRIG_THRESH   (TRIG),
    .RELEASE_THRESH(REL),
    .TRIG_COUNT    (TCNT),
    .QUIET_COUNT   (QCNT),
    .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_sample_valid(sv),
    .i_xdata_scaled(x),
    .i_ydata_scaled(y),
    .i_zdata_scaled(z),
    .i_clear_count (clr),
    .o_alarm       (o_alarm),
    .o_event_pulse (o_event_pulse),
    .o_peak        (o_peak),
    .o_peak_axis   (o_peak_axis),
    .o_event_count (o_event_count),
    .o_state       (o_state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_exc = 0; m_quiet = 0; m_hold = 0; m_count = 0;
    m_peak = '0; m_axis = '0; m_pulse = 0; m_alarm = 0;
    s1_v = 0; s1_mag = '0; s1_axis = '0;
  endtask

  task automatic ref_mag(input logic [23:0] ax, ay, az, output logic [23:0] mag,
                         output logic [1:0] axis);
`ifdef QUAKE_VECTOR_SUM_EN
    longint s;
    s = longint'(ax) + longint'(ay) + longint'(az);
    mag  = (s > 64'hFFFFFF) ? 24'hFFFFFF : s[23:0];
    axis = 2'd3;
`else
    if (ax >= ay && ax >= az) begin mag = ax; axis = 2'd0; end
    else if (ay >= az)        begin mag = ay; axis = 2'd1; end
    else                      begin mag = az; axis = 2'd2; end
`endif
  endtask

  // One clock edge of the reference: decide on the sample captured last edge
  task automatic model_edge();
    bit start;
    start = 0;
    if (m_state == 3) begin
      m_hold--;
      if (m_hold <= 0) m_state = 0;
    end else if (s1_v) begin
      if (m_state < 2) begin
        if (s1_mag >= TRIG) begin
          if (m_state == 0) begin m_peak = s1_mag; m_axis = s1_axis; end
          else if (s1_mag > m_peak) begin m_peak = s1_mag; m_axis = s1_axis; end
          m_exc++;
          if (m_exc >= TCNT) begin m_state = 2; start = 1; m_quiet = 0; end
          else m_state = 1;
        end else begin
          m_exc = 0; m_state = 0;
        end
      end else begin
        if (s1_mag > m_peak) begin m_peak = s1_mag; m_axis = s1_axis; end
        if (s1_mag < REL) m_quiet++; else m_quiet = 0;
        if (m_quiet >= QCNT) begin
          m_state = 3; m_hold = (HOLD == 0) ? 1 : HOLD; m_exc = 0; m_quiet = 0;
        end
      end
    end
    m_alarm = (m_state == 2);
    m_pulse = start;
    if (clr) m_count = 0;
    if (start && m_count < 255) m_count++;
    s1_v = sv;
    if (sv) ref_mag(x, y, z, s1_mag, s1_axis);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input logic [23:0] dx, dy, dz, input bit c);
    sv = v; x = dx; y = dy; z = dz; clr = c;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, '0, '0, 0);
  endtask

  // Called one time unit after a posedge; asserts then releases away from edges
  task automatic do_reset();
    sv = 0; x = '0; y = '0; z = '0; clr = 0;
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [60:0] obs;
    do_reset();
    idle(1);
    obs = {o_alarm, o_event_pulse, o_peak, o_peak_axis, o_event_count, o_state};
    checks++;
    if (obs !== '0) $display("FAIL reset_init: got %h want 0", obs); else passed++;
    for (int i = 0; i < 4; i++) drive(1, 24'h050000, 24'h001234, 24'h000777, 0);
    idle(1);
    checks++;
    if (o_state !== 2'd2) $display("FAIL reset_pre_alarm: state %0d want 2", o_state);
    else passed++;
    #2;
    sv = 1; x = 24'hABCDEF; y = 24'h123456; z = 24'hFFFFFF; clr = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    obs = {o_alarm, o_event_pulse, o_peak, o_peak_axis, o_event_count, o_state};
    checks++;
    if (obs !== '0) $display("FAIL reset_async: got %h want 0", obs); else passed++;
    sv = 0; x = '0; y = '0; z = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      checks++;
      if (o_event_pulse !== 1'b0 || o_state !== 2'd0)
        $display("FAIL reset_release: pulse %b state %0d want 0/0", o_event_pulse, o_state);
      else passed++;
    end
  endtask

  task automatic test_trigger();
    int pulses, pidx;
    pulses = 0; pidx = -1;
    do_reset();
    idle(1);
    for (int i = 0; i < 9; i++) begin
      if (i < 4) drive(1, 24'h050000, '0, '0, 0);
      else idle(1);
      if (o_event_pulse) begin pulses++; pidx = i; end
    end
    checks++;
    if (pulses !== 1 || pidx !== 4)
      $display("FAIL trig_pulse: pulses %0d at tick %0d want 1 at tick 4", pulses, pidx);
    else passed++;
    checks++;
    if ({o_alarm, o_event_count, o_peak, o_peak_axis} !== {1'b1, 8'd1, 24'h050000, XAXIS})
      $display("FAIL trig_outputs: alarm %b cnt %0d peak %h axis %0d want 1 1 050000 %0d",
               o_alarm, o_event_count, o_peak, o_peak_axis, XAXIS);
    else passed++;
  endtask

  task automatic test_glitch();
    int pulses;
    pulses = 0;
    do_reset();
    idle(1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 24'h050000, '0, '0, 0);
      pulses += int'(o_event_pulse);
    end
    drive(1, '0, 24'h03FFFF, '0, 0);
    pulses += int'(o_event_pulse);
    idle(1);
    pulses += int'(o_event_pulse);
    checks++;
    if (o_state !== 2'd0 || pulses !== 0 || o_event_count !== 8'd0)
      $display("FAIL glitch_reject: state %0d pulses %0d cnt %0d want 0 0 0",
               o_state, pulses, o_event_count);
    else passed++;
    for (int i = 0; i < 4; i++) drive(1, 24'h040000, '0, '0, 0);
    idle(1);
    checks++;
    if (o_state !== 2'd2 || o_event_pulse !== 1'b1 || o_peak !== 24'h040000)
      $display("FAIL glitch_boundary: state %0d pulse %b peak %h want 2 1 040000",
               o_state, o_event_pulse, o_peak);
    else passed++;
  endtask

  task automatic test_release();
    int n;
    bit other_seen;
    do_reset();
    idle(1);
    for (int i = 0; i < 4; i++) drive(1, 24'h050000, '0, '0, 0);
    for (int i = 0; i < 7; i++) drive(1, 24'h010000, '0, '0, 0);
    drive(1, 24'h020000, '0, '0, 0);
    idle(1);
    checks++;
    if (o_state !== 2'd2 || o_alarm !== 1'b1)
      $display("FAIL release_hyst: state %0d alarm %b want 2 1", o_state, o_alarm);
    else passed++;
    for (int i = 0; i < 8; i++) drive(1, 24'h010000, '0, '0, 0);
    idle(1);
    checks++;
    if (o_state !== 2'd3 || o_alarm !== 1'b0)
      $display("FAIL release_enter_hold: state %0d alarm %b want 3 0", o_state, o_alarm);
    else passed++;
    n = 1; other_seen = 0;
    for (int i = 0; i < 40 && !other_seen; i++) begin
      drive(1, 24'h070000, '0, '0, 0);
      if (o_state === 2'd3) n++; else other_seen = 1;
    end
    checks++;
    if (n !== HOLD || o_state !== 2'd0 || o_event_count !== 8'd1)
      $display("FAIL release_holdoff: hold %0d cycles then state %0d cnt %0d want %0d 0 1",
               n, o_state, o_event_count, HOLD);
    else passed++;
  endtask

  task automatic test_peak_tie();
`ifdef QUAKE_VECTOR_SUM_EN
    logic [23:0] tie_peak = 24'h120000;
`else
    logic [23:0] tie_peak = 24'h090000;
`endif
    do_reset();
    idle(1);
    for (int i = 0; i < 4; i++) drive(1, 24'h050000, '0, '0, 0);
    drive(1, 24'h090000, '0, 24'h090000, 0);
    idle(1);
    checks++;
    if (o_peak !== tie_peak || o_peak_axis !== XAXIS)
      $display("FAIL peak_tie: peak %h axis %0d want %h %0d", o_peak, o_peak_axis,
               tie_peak, XAXIS);
    else passed++;
    drive(1, '0, '0, 24'h090000, 0);
    idle(1);
    checks++;
    if (o_peak !== tie_peak || o_peak_axis !== XAXIS)
      $display("FAIL peak_equal_z: peak %h axis %0d want %h %0d", o_peak, o_peak_axis,
               tie_peak, XAXIS);
    else passed++;
  endtask

  task automatic test_saturation();
`ifdef QUAKE_VECTOR_SUM_EN
    logic [1:0] want_axis = 2'd3;
`else
    logic [1:0] want_axis = 2'd0;
`endif
    do_reset();
    idle(1);
    for (int i = 0; i < 4; i++) drive(1, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 0);
    idle(1);
    checks++;
    if (o_peak !== 24'hFFFFFF || o_peak_axis !== want_axis || o_alarm !== 1'b1)
      $display("FAIL sat_peak: peak %h axis %0d alarm %b want FFFFFF %0d 1",
               o_peak, o_peak_axis, o_alarm, want_axis);
    else passed++;
  endtask

  task automatic one_event();
    for (int i = 0; i < 4; i++) drive(1, 24'h060000, '0, '0, 0);
    for (int i = 0; i < 8; i++) drive(1, '0, '0, '0, 0);
    for (int i = 0; i < 40 && o_state !== 2'd0; i++) idle(1);
  endtask

  task automatic test_counter();
    do_reset();
    idle(1);
    for (int e = 0; e < 255; e++) one_event();
    checks++;
    if (o_event_count !== 8'd255 || o_state !== 2'd0)
      $display("FAIL count_255: cnt %0d state %0d want 255 0", o_event_count, o_state);
    else passed++;
    one_event();
    checks++;
    if (o_event_count !== 8'd255)
      $display("FAIL count_saturate: cnt %0d want 255", o_event_count);
    else passed++;
    for (int i = 0; i < 4; i++) drive(1, 24'h060000, '0, '0, 0);
    drive(0, '0, '0, '0, 1);
    checks++;
    if (o_event_pulse !== 1'b1 || o_event_count !== 8'd1)
      $display("FAIL count_clear_inc: pulse %b cnt %0d want 1 1", o_event_pulse, o_event_count);
    else passed++;
    drive(0, '0, '0, '0, 1);
    checks++;
    if (o_event_count !== 8'd0)
      $display("FAIL count_clear: cnt %0d want 0", o_event_count);
    else passed++;
  endtask

  function automatic logic [23:0] rnd_mag(bit loud);
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 24'h040000;
    if (r == 1) return 24'h03FFFF;
    if (r == 2) return 24'h020000;
    if (r == 3) return 24'h01FFFF;
    if (loud) return 24'h040000 + 24'($urandom_range(0, 24'h0C0000));
    return 24'($urandom_range(0, 24'h00A000));
  endfunction

  task automatic test_random();
    bit loud;
    logic [60:0] obs, exp;
    do_reset();
    idle(1);
    loud = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 24 == 0) loud = ($urandom_range(0, 1) == 1);
      drive($urandom_range(0, 3) != 0, rnd_mag(loud), rnd_mag(loud && $urandom_range(0, 1) == 1),
            rnd_mag(loud && $urandom_range(0, 2) == 0), $urandom_range(0, 63) == 0);
      obs = {o_alarm, o_event_pulse, o_peak, o_peak_axis, o_event_count, o_state};
      exp = {m_alarm, m_pulse, m_peak, m_axis, 8'(m_count), 2'(m_state)};
      checks++;
      if (obs !== exp) $display("FAIL random_cycle %0d: got %h want %h", i, obs, exp);
      else passed++;
    end
  endtask

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    idle(1);
    test_reset();
    test_trigger();
    test_glitch();
    test_release();
    test_peak_tie();
    test_saturation();
    test_counter();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
